// File: rtl/frame_gen_pkg.sv
// Shared definitions for the serial frame generator: payload-source encodings
// and the maximal-length LFSR tap table.
package frame_gen_pkg;

    typedef enum logic [1:0] {
        MODE_INC     = 2'd0,
        MODE_LOAD    = 2'd1,
        MODE_PRBS    = 2'd2,
        MODE_INC_INV = 2'd3
    } mode_e;

    // Fibonacci feedback taps, bit k set means state bit k feeds the XOR.
    function automatic logic [15:0] tap_mask(input int width);
        logic [15:0] m;
        case (width)
            4:       m = 16'h000C;
            5:       m = 16'h0014;
            6:       m = 16'h0030;
            7:       m = 16'h0060;
            8:       m = 16'h00B8;
            9:       m = 16'h0110;
            10:      m = 16'h0240;
            11:      m = 16'h0500;
            12:      m = 16'h0829;
            13:      m = 16'h100D;
            14:      m = 16'h2015;
            15:      m = 16'h6000;
            16:      m = 16'hD008;
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// Left-shifting Fibonacci LFSR; advances one state per step pulse and
// recovers from the lock-up (all-zero) state by jumping to all-ones.
module prbs_lfsr
    import frame_gen_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    output logic [WIDTH-1:0] state
);

    localparam logic [15:0] TAPS = tap_mask(WIDTH);

    logic [WIDTH-1:0] shifted;

    assign shifted = {state[WIDTH-2:0], ^(state & TAPS[WIDTH-1:0])};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= '1;
        end else if (step) begin
            state <= (shifted == '0) ? '1 : shifted;
        end
    end

endmodule

// File: rtl/frame_word_gen.sv
// Serial frame generator: start bit, payload (optionally inverted), optional
// even parity, stop bit, shifted out LSB-first with a slow payload update.
module frame_word_gen
    import frame_gen_pkg::*;
#(
    parameter int DATA_W     = 10,
    parameter int UPDATE_DIV = 16777216,
    parameter int PARITY_EN  = 0
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       en,
    input  logic [1:0]                                 mode,
    input  logic [DATA_W-1:0]                          load_val,
    output logic [DATA_W+2+PARITY_EN-1:0]              word,
    output logic                                       newres,
    output logic                                       txbit,
    output logic [$clog2(DATA_W+2+PARITY_EN)-1:0]      bitpos
);

    localparam int FRAME_W = DATA_W + 2 + PARITY_EN;
    localparam int BP_W    = $clog2(FRAME_W);
    localparam int SC_W    = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;

    localparam logic [BP_W-1:0] LAST_POS = BP_W'(FRAME_W - 1);
    localparam logic [SC_W-1:0] LAST_CNT = SC_W'(UPDATE_DIV - 1);
    localparam logic [15:0]     TAPS     = tap_mask(DATA_W);

    mode_e             cur_mode;
    logic [SC_W-1:0]   slowcnt;
    logic [DATA_W-1:0] payload;
    logic [DATA_W-1:0] field;
    logic [DATA_W-1:0] lfsr_state;
    logic [DATA_W-1:0] lfsr_shift;
    logic [DATA_W-1:0] lfsr_nxt;
    logic              invert;
    logic              update;
    logic              lfsr_step;

    assign cur_mode  = mode_e'(mode);
    assign newres    = en && (bitpos == LAST_POS);
    assign update    = newres && (slowcnt == LAST_CNT);
    assign lfsr_step = update && (cur_mode == MODE_PRBS);
    assign field     = payload ^ {DATA_W{invert}};
    assign txbit     = en ? word[bitpos] : 1'b1;

    // The payload takes the value the LFSR moves to on this same edge.
    assign lfsr_shift = {lfsr_state[DATA_W-2:0], ^(lfsr_state & TAPS[DATA_W-1:0])};
    assign lfsr_nxt   = (lfsr_shift == '0) ? '1 : lfsr_shift;

    generate
        if (PARITY_EN != 0) begin : g_par
            assign word = {1'b1, ^field, field, 1'b0};
        end else begin : g_nopar
            assign word = {1'b1, field, 1'b0};
        end
    endgenerate

    prbs_lfsr #(
        .WIDTH (DATA_W)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (lfsr_step),
        .state (lfsr_state)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitpos <= '0;
        end else if (en) begin
            bitpos <= (bitpos == LAST_POS) ? '0 : bitpos + BP_W'(1);
        end
    end

    // Everything that shapes the frame image moves only at a frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slowcnt <= '0;
            payload <= '0;
            invert  <= 1'b0;
        end else if (newres) begin
            slowcnt <= update ? '0 : slowcnt + SC_W'(1);
            invert  <= (cur_mode == MODE_INC_INV) ? ~invert : 1'b0;
            if (update) begin
                case (cur_mode)
                    MODE_LOAD: payload <= load_val;
                    MODE_PRBS: payload <= lfsr_nxt;
                    default:   payload <= payload + DATA_W'(1);
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_word_gen.sv
// Bench for frame_word_gen: a frame-level reference model predicts every
// frame image, with a second instance covering the parity variant.
module tb_frame_word_gen;

    localparam int DW  = 10;
    localparam int DIV = 2;
    localparam int FW  = 12;
    localparam int FWP = 13;

    localparam logic [1:0] M_INC  = 2'd0;
    localparam logic [1:0] M_LOAD = 2'd1;
    localparam logic [1:0] M_PRBS = 2'd2;
    localparam logic [1:0] M_INV  = 2'd3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          en_p;
    logic [1:0]    mode;
    logic [DW-1:0] load_val;

    logic [FW-1:0]  word;
    logic           newres;
    logic           txbit;
    logic [3:0]     bitpos;
    logic [FWP-1:0] word_p;
    logic           newres_p;
    logic           txbit_p;
    logic [3:0]     bitpos_p;

    int n_checks = 0;
    int n_fail   = 0;

    logic [FW-1:0] exp_q[$];
    int m_pay;
    int m_cnt;
    bit m_inv;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    frame_word_gen #(.DATA_W(DW), .UPDATE_DIV(DIV), .PARITY_EN(0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load_val(load_val),
        .word(word), .newres(newres), .txbit(txbit), .bitpos(bitpos)
    );

    frame_word_gen #(.DATA_W(DW), .UPDATE_DIV(DIV), .PARITY_EN(1)) dut_p (
        .clk(clk), .rst_n(rst_n), .en(en_p), .mode(mode), .load_val(load_val),
        .word(word_p), .newres(newres_p), .txbit(txbit_p), .bitpos(bitpos_p)
    );

    // ---------------- reference model ----------------
    function automatic int model_field();
        return m_inv ? (1023 - m_pay) : m_pay;
    endfunction

    function automatic logic [FW-1:0] model_word();
        return FW'(2048 + 2 * model_field());
    endfunction

    function automatic logic [FWP-1:0] model_word_p();
        int f;
        f = model_field();
        return FWP'(4096 + ($countones(f) % 2) * 2048 + 2 * f);
    endfunction

    task automatic model_reset();
        m_pay = 0;
        m_cnt = 0;
        m_inv = 1'b0;
        exp_q.delete();
        exp_q.push_back(model_word());
    endtask

    task automatic model_boundary(input logic [1:0] m, input int lv);
        bit upd;
        upd = (m_cnt == DIV - 1);
        m_cnt = upd ? 0 : m_cnt + 1;
        if (upd) begin
            if (m == M_LOAD) m_pay = lv;
            else             m_pay = (m_pay + 1) % 1024;
        end
        m_inv = (m == M_INV) ? !m_inv : 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input bit e);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        en    = e;
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic run_frame(input logic [1:0] m_start, input logic [1:0] m_end,
                             input logic [DW-1:0] lv_start, input logic [DW-1:0] lv_end,
                             input int change_at, input int gap_at, input string name);
        logic [FW-1:0] exp;
        exp = exp_q.pop_front();
        mode = m_start;
        load_val = lv_start;
        for (int i = 0; i < FW; i++) begin
            if (i == change_at) begin
                mode = m_end;
                load_val = lv_end;
            end
            if (i == gap_at) begin
                en = 1'b0;
                #1;
                for (int g = 0; g < 7; g++) begin
                    n_checks++;
                    if (txbit !== 1'b1 || bitpos !== 4'(i) || newres !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s gap cyc %0d: txbit=%b bitpos=%0d newres=%b want 1/%0d/0",
                                 name, g, txbit, bitpos, newres, i);
                    end
                    step();
                end
                en = 1'b1;
                #1;
            end
            n_checks++;
            if (bitpos !== 4'(i)) begin
                n_fail++;
                $display("FAIL %s bitpos: got %0d want %0d", name, bitpos, i);
            end
            n_checks++;
            if (word !== exp) begin
                n_fail++;
                $display("FAIL %s word at bit %0d: got %h want %h", name, i, word, exp);
            end
            n_checks++;
            if (txbit !== exp[i]) begin
                n_fail++;
                $display("FAIL %s txbit at bit %0d: got %b want %b", name, i, txbit, exp[i]);
            end
            n_checks++;
            if (newres !== (i == FW - 1)) begin
                n_fail++;
                $display("FAIL %s newres at bit %0d: got %b want %b", name, i, newres, (i == FW - 1));
            end
            step();
        end
        model_boundary(m_end, int'(lv_end));
        exp_q.push_back(model_word());
    endtask

    task automatic run_frame_p(input logic [1:0] m, input logic [DW-1:0] lv);
        logic [FWP-1:0] exp;
        exp = model_word_p();
        mode = m;
        load_val = lv;
        for (int i = 0; i < FWP; i++) begin
            n_checks++;
            if (bitpos_p !== 4'(i) || word_p !== exp || txbit_p !== exp[i] ||
                newres_p !== (i == FWP - 1)) begin
                n_fail++;
                $display("FAIL parity frame bit %0d: bitpos=%0d word=%h txbit=%b newres=%b want %0d/%h/%b/%b",
                         i, bitpos_p, word_p, txbit_p, newres_p, i, exp, exp[i], (i == FWP - 1));
            end
            step();
        end
        model_boundary(m, int'(lv));
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b1; en = 1'b0; en_p = 1'b0; mode = M_INC; load_val = '0;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bitpos !== 4'd0 || word !== 12'h800 || newres !== 1'b0 || txbit !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_idle: bitpos=%0d word=%h newres=%b txbit=%b want 0/800/0/1",
                     bitpos, word, newres, txbit);
        end
        n_checks++;
        if (word_p !== 13'h1000) begin
            n_fail++;
            $display("FAIL reset_parity_word: got %h want 1000", word_p);
        end
        en = 1'b1;
        #1;
        n_checks++;
        if (txbit !== 1'b0 || newres !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_en: txbit=%b newres=%b want 0/0", txbit, newres);
        end
        #5;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_inc();
        run_frame(M_INC, M_INC, '0, '0, 0, -1, "inc_f1");
        run_frame(M_INC, M_INC, '0, '0, 0, -1, "inc_f2");
        n_checks++;
        if (word !== 12'h802) begin
            n_fail++;
            $display("FAIL inc_first_update: got %h want 802", word);
        end
        run_frame(M_INC, M_INC, '0, '0, 0, -1, "inc_f3");
        run_frame(M_INC, M_INC, '0, '0, 0, -1, "inc_f4");
    endtask

    task automatic test_load_wrap();
        apply_reset(1'b1);
        run_frame(M_LOAD, M_LOAD, 10'h3FF, 10'h3FF, 0, -1, "load_f1");
        run_frame(M_LOAD, M_LOAD, 10'h3FF, 10'h3FF, 0, -1, "load_f2");
        n_checks++;
        if (word !== 12'hFFE) begin
            n_fail++;
            $display("FAIL load_value: got %h want ffe", word);
        end
        run_frame(M_INC, M_INC, '0, '0, 0, -1, "wrap_f1");
        run_frame(M_INC, M_INC, '0, '0, 0, -1, "wrap_f2");
        n_checks++;
        if (word !== 12'h800) begin
            n_fail++;
            $display("FAIL inc_wrap: got %h want 800", word);
        end
    endtask

    task automatic test_inc_inv();
        int exp_f[6] = '{0, 1023, 1, 1022, 2, 1021};
        apply_reset(1'b1);
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (word[10:1] !== 10'(exp_f[k])) begin
                n_fail++;
                $display("FAIL inc_inv_field f%0d: got %h want %h", k, word[10:1], exp_f[k]);
            end
            run_frame(M_INV, M_INV, '0, '0, 0, -1, "inc_inv");
        end
    endtask

    task automatic test_en_gap();
        apply_reset(1'b1);
        run_frame(M_INC, M_INC, '0, '0, 0, 5, "en_gap");
        run_frame(M_INC, M_INC, '0, '0, 0, -1, "after_gap");
    endtask

    task automatic test_random();
        logic [1:0] ms, me;
        int sel, ch, gp;
        apply_reset(1'b1);
        for (int k = 0; k < 40; k++) begin
            ms  = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 2);
            me  = (sel == 2) ? M_INV : 2'(sel);
            ch  = $urandom_range(0, FW - 1);
            gp  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, FW - 1) : -1;
            run_frame(ms, me, 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                      ch, gp, "random");
        end
    endtask

    task automatic test_parity();
        logic [DW-1:0] lv;
        en_p = 1'b1;
        apply_reset(1'b0);
        run_frame_p(M_LOAD, 10'h007);
        run_frame_p(M_LOAD, 10'h007);
        n_checks++;
        if (word_p !== 13'h180E) begin
            n_fail++;
            $display("FAIL parity_word_007: got %h want 180e", word_p);
        end
        repeat (8) step();
        n_checks++;
        if (bitpos_p !== 4'd8) begin
            n_fail++;
            $display("FAIL parity_pos_before_reset: got %0d want 8", bitpos_p);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bitpos_p !== 4'd0 || word_p !== 13'h1000 || newres_p !== 1'b0 || txbit_p !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_async_reset: bitpos=%0d word=%h newres=%b txbit=%b want 0/1000/0/0",
                     bitpos_p, word_p, newres_p, txbit_p);
        end
        n_checks++;
        if (word !== 12'h800 || txbit !== 1'b1 || bitpos !== 4'd0) begin
            n_fail++;
            $display("FAIL async_reset_idle: word=%h txbit=%b bitpos=%0d want 800/1/0",
                     word, txbit, bitpos);
        end
        #2;
        rst_n = 1'b1;
        model_reset();
        run_frame_p(M_LOAD, 10'h3A5);
        for (int k = 0; k < 4; k++) begin
            lv = 10'($urandom_range(0, 1023));
            run_frame_p(M_LOAD, lv);
            run_frame_p(M_LOAD, lv);
        end
        en_p = 1'b0;
    endtask

    task automatic test_prbs();
        bit seen[1024];
        logic [DW-1:0] v;
        apply_reset(1'b1);
        mode = M_PRBS;
        foreach (seen[i]) seen[i] = 1'b0;
        seen[1023] = 1'b1;
        for (int u = 1; u <= 1023; u++) begin
            repeat (2 * FW) step();
            v = word[10:1];
            if (u < 1023) begin
                n_checks++;
                if (v == '0 || seen[v]) begin
                    n_fail++;
                    $display("FAIL prbs_unique update %0d: got %h (zero or repeat)", u, v);
                end
                seen[v] = 1'b1;
            end else begin
                n_checks++;
                if (v !== 10'h3FF) begin
                    n_fail++;
                    $display("FAIL prbs_period: got %h want 3ff", v);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_inc();
        test_load_wrap();
        test_inc_inv();
        test_en_gap();
        test_random();
        test_parity();
        test_prbs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
